axi_sync_bridge: RTL



---
 rtl/axi_sync_bridge_if.sv | 41 ++++
 rtl/axi_sync_bridge.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_sync_bridge_if.sv
// AXI channel bundle shared by both sides of axi_sync_bridge.
// R carries no last flag: the bridge derives it from arlen.
interface axi_interface #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic                  bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awlen, awvalid, input awready,
        output wdata, wlast, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arlen, arvalid, input arready,
        input rdata, rvalid, output rready
    );

    modport slave (
        input awaddr, awlen, awvalid, output awready,
        input wdata, wlast, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arlen, arvalid, output arready,
        output rdata, rvalid, input rready
    );
endinterface

// File: rtl/axi_sync_bridge.sv
// Single-clock AXI buffering bridge: one FIFO per channel, outstanding-burst limits,
// R last-beat generation from arlen. Optional counters under AXI_SYNC_BRIDGE_PERF_EN.
module axi_sync_bridge_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push_i && !full_q;
        do_pop   = pop_i && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (do_pop && !do_push) count_d = count_q - 1'b1;
        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
endmodule

module axi_sync_bridge #(
    parameter int ADDR_WIDTH          = 32,
    parameter int DATA_WIDTH          = 32,
    parameter int CONTROL_FIFO_LENGTH = 2,
    parameter int DATA_FIFO_LENGTH    = 8,
    parameter int MAX_OUTSTANDING     = 4
) (
    input  logic         clk,
    input  logic         reset,
    axi_interface.slave  axi_bus_s,
    axi_interface.master axi_bus_m,
    output logic         read_last_s
`ifdef AXI_SYNC_BRIDGE_PERF_EN
    ,
    output logic [31:0]  perf_read_bursts,
    output logic [31:0]  perf_write_bursts
`endif
);
    localparam int AXW = ADDR_WIDTH + 8;
    localparam int WW  = DATA_WIDTH + 1;
    localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);

    logic           aw_full, aw_empty, w_full, w_empty, b_full, b_empty;
    logic           ar_full, ar_empty, r_full, r_empty, len_full, len_empty;
    logic [AXW-1:0] aw_dout, ar_dout;
    logic [WW-1:0]  w_dout;
    logic           b_dout;
    logic [7:0]     len_head;
    logic [7:0]     wr_out_q, wr_out_d, rd_out_q, rd_out_d, beat_q, beat_d;
    logic           aw_hs_s, b_hs_s, ar_hs_s, r_hs_s, last_hs;

    function automatic logic [7:0] step_count(input logic [7:0] cur, input logic inc, input logic dec);
        if (inc && !dec) return cur + 8'd1;
        if (dec && !inc && cur != 8'd0) return cur - 8'd1;
        return cur;
    endfunction

    // Write channels
    assign axi_bus_s.awready = !aw_full && (wr_out_q < MAX_OUT);
    assign aw_hs_s           = axi_bus_s.awvalid && axi_bus_s.awready;
    assign axi_bus_m.awvalid = !aw_empty;
    assign {axi_bus_m.awaddr, axi_bus_m.awlen} = aw_dout;

    axi_sync_bridge_fifo #(.WIDTH(AXW), .DEPTH(CONTROL_FIFO_LENGTH)) u_aw_fifo (
        .clk_i(clk), .reset_i(reset), .push_i(aw_hs_s),
        .din_i({axi_bus_s.awaddr, axi_bus_s.awlen}),
        .pop_i(axi_bus_m.awready), .dout_o(aw_dout), .full_o(aw_full), .empty_o(aw_empty)
    );

    assign axi_bus_s.wready = !w_full;
    assign axi_bus_m.wvalid = !w_empty;
    assign {axi_bus_m.wdata, axi_bus_m.wlast} = w_dout;

    axi_sync_bridge_fifo #(.WIDTH(WW), .DEPTH(DATA_FIFO_LENGTH)) u_w_fifo (
        .clk_i(clk), .reset_i(reset), .push_i(axi_bus_s.wvalid),
        .din_i({axi_bus_s.wdata, axi_bus_s.wlast}),
        .pop_i(axi_bus_m.wready), .dout_o(w_dout), .full_o(w_full), .empty_o(w_empty)
    );

    assign axi_bus_m.bready = !b_full;
    assign axi_bus_s.bvalid = !b_empty;
    assign axi_bus_s.bresp  = b_dout;
    assign b_hs_s           = axi_bus_s.bvalid && axi_bus_s.bready;

    axi_sync_bridge_fifo #(.WIDTH(1), .DEPTH(CONTROL_FIFO_LENGTH)) u_b_fifo (
        .clk_i(clk), .reset_i(reset), .push_i(axi_bus_m.bvalid), .din_i(axi_bus_m.bresp),
        .pop_i(axi_bus_s.bready), .dout_o(b_dout), .full_o(b_full), .empty_o(b_empty)
    );

    // Read channels; len_full never asserts while rd_out is below the limit
    assign axi_bus_s.arready = !ar_full && !len_full && (rd_out_q < MAX_OUT);
    assign ar_hs_s           = axi_bus_s.arvalid && axi_bus_s.arready;
    assign axi_bus_m.arvalid = !ar_empty;
    assign {axi_bus_m.araddr, axi_bus_m.arlen} = ar_dout;

    axi_sync_bridge_fifo #(.WIDTH(AXW), .DEPTH(CONTROL_FIFO_LENGTH)) u_ar_fifo (
        .clk_i(clk), .reset_i(reset), .push_i(ar_hs_s),
        .din_i({axi_bus_s.araddr, axi_bus_s.arlen}),
        .pop_i(axi_bus_m.arready), .dout_o(ar_dout), .full_o(ar_full), .empty_o(ar_empty)
    );

    assign axi_bus_m.rready = !r_full;
    assign axi_bus_s.rvalid = !r_empty;
    assign r_hs_s           = axi_bus_s.rvalid && axi_bus_s.rready;

    axi_sync_bridge_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DATA_FIFO_LENGTH)) u_r_fifo (
        .clk_i(clk), .reset_i(reset), .push_i(axi_bus_m.rvalid), .din_i(axi_bus_m.rdata),
        .pop_i(axi_bus_s.rready), .dout_o(axi_bus_s.rdata), .full_o(r_full), .empty_o(r_empty)
    );

    axi_sync_bridge_fifo #(.WIDTH(8), .DEPTH(MAX_OUTSTANDING)) u_len_fifo (
        .clk_i(clk), .reset_i(reset), .push_i(ar_hs_s), .din_i(axi_bus_s.arlen),
        .pop_i(last_hs), .dout_o(len_head), .full_o(len_full), .empty_o(len_empty)
    );

    assign read_last_s = axi_bus_s.rvalid && !len_empty && (beat_q == len_head);
    assign last_hs     = r_hs_s && read_last_s;

    always_comb begin
        wr_out_d = step_count(wr_out_q, aw_hs_s, b_hs_s);
        rd_out_d = step_count(rd_out_q, ar_hs_s, last_hs);
        beat_d   = beat_q;
        if (last_hs)     beat_d = 8'd0;
        else if (r_hs_s) beat_d = beat_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_out_q <= 8'd0;
            rd_out_q <= 8'd0;
            beat_q   <= 8'd0;
        end else begin
            wr_out_q <= wr_out_d;
            rd_out_q <= rd_out_d;
            beat_q   <= beat_d;
        end
    end

`ifdef AXI_SYNC_BRIDGE_PERF_EN
    logic [31:0] perf_rd_q, perf_wr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_rd_q <= 32'd0;
            perf_wr_q <= 32'd0;
        end else begin
            if (last_hs) perf_rd_q <= perf_rd_q + 32'd1;
            if (b_hs_s)  perf_wr_q <= perf_wr_q + 32'd1;
        end
    end

    assign perf_read_bursts  = perf_rd_q;
    assign perf_write_bursts = perf_wr_q;
`endif
endmodule
